acc_core_mc: RTL and testbench

//  Parametrised multi-cycle accumulator CPU core; next generation of the team's fixed 16-bit accumulator machine.

---
 rtl/acc_pkg.sv | 46 ++++
 rtl/acc_alu.sv | 34 +++
 rtl/acc_core_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_acc_core_mc.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
`default_nettype none
// =============================================================================
//  acc_pkg
//  Opcodes, FSM state encoding, ALU selects and width helper for acc_core_mc.
//  Revision: 1.0
// =============================================================================
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_ST   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_BNE  = 4'd10;
    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_IN   = 4'd12;
    localparam logic [3:0] OP_OUT  = 4'd13;
    localparam logic [3:0] OP_STK  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // The opcode field must not overlap the address immediate.
    function automatic bit acc_width_ok(input int data_w, input int addr_w);
        return data_w >= addr_w + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// =============================================================================
//  acc_alu
//  Combinational accumulator ALU: pass/add/sub/and/or plus accumulator-zero flag.
//  Revision: 1.0
// =============================================================================
module acc_alu
    import acc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o,
    output logic              zero_o
);

    always_comb begin
        y_o = b_i;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = b_i;
        endcase
    end

    // Branches test the accumulator operand, not the ALU result.
    assign zero_o = (a_i == '0);

endmodule
`default_nettype wire

// File: rtl/acc_core_mc.sv
`default_nettype none
// =============================================================================
//  acc_core_mc
//  Multi-cycle accumulator core with valid/ready memory port.
//  Optional stack (op 14 PUSH/POP with SP register) enabled by ACC_STACK_EN.
//  Revision: 1.0
// =============================================================================
module acc_core_mc
    import acc_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 12,
    parameter logic [ADDR_W-1:0] PC_RST = '0
`ifdef ACC_STACK_EN
    ,
    parameter logic [ADDR_W-1:0] SP_RST = '1
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_vld,
    output logic              halted
);

    localparam int                EXT_W    = DATA_W - ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    if (!acc_width_ok(DATA_W, ADDR_W)) begin : g_width_check
        $error("acc_core_mc: DATA_W must be at least ADDR_W + 4");
    end

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] dr_q;
    logic [DATA_W-1:0] io_out_q;
    logic              io_out_vld_q;
    logic              halted_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
`ifdef ACC_STACK_EN
    logic [ADDR_W-1:0] sp_q;
`endif

    logic [3:0]        op;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] imm_ze;
    logic [DATA_W-1:0] imm_se;

    assign op     = ir_q[DATA_W-1 -: 4];
    assign imm    = ir_q[ADDR_W-1:0];
    assign imm_ze = {{EXT_W{1'b0}}, imm};
    assign imm_se = {{EXT_W{imm[ADDR_W-1]}}, imm};

    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] acc_d;
    logic              acc_zero;
    logic              acc_we;

    acc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i   (alu_op),
        .a_i    (acc_q),
        .b_i    (alu_b),
        .y_o    (acc_d),
        .zero_o (acc_zero)
    );

    always_comb begin
        alu_op = ALU_PASS;
        alu_b  = acc_q;
        acc_we = 1'b0;
        case (op)
            OP_LDI:  begin alu_b = imm_ze; acc_we = 1'b1; end
            OP_LD:   begin alu_b = dr_q;   acc_we = 1'b1; end
            OP_ADD:  begin alu_op = ALU_ADD; alu_b = dr_q;   acc_we = 1'b1; end
            OP_SUB:  begin alu_op = ALU_SUB; alu_b = dr_q;   acc_we = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; alu_b = dr_q;   acc_we = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  alu_b = dr_q;   acc_we = 1'b1; end
            OP_ADDI: begin alu_op = ALU_ADD; alu_b = imm_se; acc_we = 1'b1; end
            OP_IN:   begin alu_b = io_in;  acc_we = 1'b1; end
`ifdef ACC_STACK_EN
            OP_STK:  if (imm[0]) begin alu_b = dr_q; acc_we = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Data-phase request set up in DECODE.
    logic              need_mem_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;

    always_comb begin
        need_mem_d = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = imm;
        case (op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR: need_mem_d = 1'b1;
            OP_ST: begin need_mem_d = 1'b1; mem_we_d = 1'b1; end
`ifdef ACC_STACK_EN
            OP_STK: begin
                need_mem_d = 1'b1;
                mem_we_d   = ~imm[0];
                mem_addr_d = imm[0] ? sp_q : (sp_q - ADDR_ONE);
            end
`endif
            default: ;
        endcase
    end

    // pc_q already points past the current instruction; a taken branch replaces it.
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        case (op)
            OP_BEQ:  if (acc_zero)  pc_d = imm;
            OP_BNE:  if (!acc_zero) pc_d = imm;
            OP_JMP:  pc_d = imm;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= PC_RST;
            ir_q         <= '0;
            acc_q        <= '0;
            dr_q         <= '0;
            io_out_q     <= '0;
            io_out_vld_q <= 1'b0;
            halted_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef ACC_STACK_EN
            sp_q         <= SP_RST;
`endif
        end else begin
            io_out_vld_q <= 1'b0;
            case (state_q)
                ST_FETCH: begin
                    // Only the first fetch after reset arrives here without a pre-armed request.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        ir_q      <= mem_rdata;
                        pc_q      <= pc_q + ADDR_ONE;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (op == OP_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else if (need_mem_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_we_d;
                        mem_addr_q  <= mem_addr_d;
                        mem_wdata_q <= acc_q;
                        state_q     <= ST_MEM;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (!mem_we_q) dr_q <= mem_rdata;
                        mem_req_q <= 1'b0;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (acc_we) acc_q <= acc_d;
                    if (op == OP_OUT) begin
                        io_out_q     <= acc_q;
                        io_out_vld_q <= 1'b1;
                    end
`ifdef ACC_STACK_EN
                    if (op == OP_STK) sp_q <= imm[0] ? (sp_q + ADDR_ONE) : (sp_q - ADDR_ONE);
`endif
                    pc_q       <= pc_d;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_d;
                    state_q    <= ST_FETCH;
                end
                ST_HALT: ;
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_FETCH;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign io_out     = io_out_q;
    assign io_out_vld = io_out_vld_q;
    assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_core_mc.sv
`default_nettype none
// =============================================================================
//  tb_acc_core_mc
//  Directed bench for acc_core_mc with a behavioural memory (zero/random/stall waits).
//  Revision: 1.0
// =============================================================================
module tb_acc_core_mc;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          CLK = 1'b0;
    logic          reset = 1'b1;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] io_in = '0;
    logic [DW-1:0] io_out;
    logic          io_out_vld, halted;

    acc_core_mc #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .PC_RST (12'h000)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_out_vld (io_out_vld),
        .halted     (halted)
    );

    initial forever #5 CLK = ~CLK;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [0:4095];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          clr_stats = 1'b0;
    logic          stall = 1'b0;
    logic          rand_mode = 1'b0;
    int            wait_left = 0;
    int            wr_cnt = 0, rd_cnt = 0, vld_cnt = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;
    logic [AW-1:0] rd_log [0:15];

    assign mem_ready = (wait_left == 0) && !(stall && mem_addr == 12'h020);
    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (!mem_req || mem_ready) wait_left <= rand_mode ? int'($urandom_range(0, 3)) : 0;
        else if (wait_left > 0)    wait_left <= wait_left - 1;
        if (ld_en) mem[ld_addr] <= ld_data;
        if (clr_stats) begin
            wr_cnt <= 0; rd_cnt <= 0; vld_cnt <= 0;
        end else begin
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr] <= mem_wdata;
                    wr_cnt  <= wr_cnt + 1;
                    last_wa <= mem_addr;
                    last_wd <= mem_wdata;
                end else begin
                    if (rd_cnt < 16) rd_log[rd_cnt] <= mem_addr;
                    rd_cnt <= rd_cnt + 1;
                end
            end
            if (io_out_vld) vld_cnt <= vld_cnt + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic          hold_chk = 1'b0;
    logic          p_pend = 1'b0;
    logic [29:0]   p_bus = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; sample at the falling edge. Also checks request stability.
    task automatic step();
        @(negedge CLK);
        if (p_pend) chk("req_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_bus[28:0]});
        p_pend = hold_chk && mem_req && !mem_ready;
        p_bus  = {1'b1, mem_we, mem_addr, mem_wdata};
    endtask

    task automatic begin_prog();
        reset     = 1'b1;
        clr_stats = 1'b1;
        p_pend    = 1'b0;
        step();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic release_prog();
        reset = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 400) begin step(); cyc++; end
        chk("halt_reached", {31'b0, halted}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [11:0] imm;
        logic [15:0] a;     // acc before the op (loaded from M[0x31])
        logic [15:0] b;     // M[0x30]
        logic [15:0] inp;   // io_in
        logic [15:0] exp;   // expected io_out
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int cyc;
    int found;

    initial begin
        vecs[0]  = '{4'h4, 12'h030, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000}; // ADD wrap
        vecs[1]  = '{4'h5, 12'h030, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF}; // SUB wrap
        vecs[2]  = '{4'h6, 12'h030, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030}; // AND
        vecs[3]  = '{4'h7, 12'h030, 16'hF0F0, 16'h0F01, 16'h0000, 16'hFFF1}; // OR
        vecs[4]  = '{4'h8, 12'hFFF, 16'h0010, 16'h0000, 16'h0000, 16'h000F}; // ADDI -1
        vecs[5]  = '{4'h8, 12'h001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000}; // ADDI wrap
        vecs[6]  = '{4'h8, 12'h800, 16'h1000, 16'h0000, 16'h0000, 16'h0800}; // ADDI -2048
        vecs[7]  = '{4'h1, 12'hABC, 16'h1234, 16'h0000, 16'h0000, 16'h0ABC}; // LDI zero-ext
        vecs[8]  = '{4'h2, 12'h030, 16'h1111, 16'h1234, 16'h0000, 16'h1234}; // LD
        vecs[9]  = '{4'hC, 12'h000, 16'h1111, 16'h0000, 16'hBEEF, 16'hBEEF}; // IN
        vecs[10] = '{4'h0, 12'h000, 16'h5555, 16'h0000, 16'h0000, 16'h5555}; // NOP

        // Table: LD 0x31; <op>; OUT; HALT
        for (int i = 0; i < NV; i++) begin
            begin_prog();
            load(12'h000, 16'h2031);
            load(12'h001, {vecs[i].op, vecs[i].imm});
            load(12'h002, 16'hD000);
            load(12'h003, 16'hF000);
            load(12'h031, vecs[i].a);
            load(12'h030, vecs[i].b);
            io_in = vecs[i].inp;
            release_prog();
            run_halt(cyc);
            chk($sformatf("vec%0d_io_out", i), {16'b0, io_out}, {16'b0, vecs[i].exp});
            chk($sformatf("vec%0d_vld_cnt", i), vld_cnt, 32'd1);
        end

        // Reset values (previous run left io_out/halted/mem_addr non-zero)
        begin_prog();
        chk("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr",  {20'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        chk("rst_io_out",    {16'b0, io_out}, 32'd0);
        chk("rst_io_vld",    {31'b0, io_out_vld}, 32'd0);
        chk("rst_halted",    {31'b0, halted}, 32'd0);

        // LDI 5; ADDI -1; OUT; HALT
        load(12'h000, 16'h1005);
        load(12'h001, 16'h8FFF);
        load(12'h002, 16'hD000);
        load(12'h003, 16'hF000);
        release_prog();
        run_halt(cyc);
        chk("p1_cycles",  cyc, 32'd12);
        chk("p1_io_out",  {16'b0, io_out}, 32'h4);
        chk("p1_vld_cnt", vld_cnt, 32'd1);
        repeat (3) step();
        chk("p1_halt_hold", {30'b0, halted, mem_req}, 32'b10);

        // LD; HALT: memory-op latency
        begin_prog();
        load(12'h000, 16'h2020);
        load(12'h001, 16'hF000);
        release_prog();
        run_halt(cyc);
        chk("ld_cycles", cyc, 32'd7);

        // LD 0x20; ADD 0x21; ST 0x22; HALT -- zero-wait then random waits
        for (int m = 0; m < 2; m++) begin
            begin_prog();
            load(12'h000, 16'h2020);
            load(12'h001, 16'h4021);
            load(12'h002, 16'h3022);
            load(12'h003, 16'hF000);
            load(12'h020, 16'h7FFF);
            load(12'h021, 16'h0001);
            load(12'h022, 16'h0000);
            rand_mode = (m == 1);
            hold_chk  = (m == 1);
            release_prog();
            run_halt(cyc);
            if (m == 0) chk("st_cycles", cyc, 32'd15);
            chk($sformatf("st%0d_wr_cnt", m), wr_cnt, 32'd1);
            chk($sformatf("st%0d_addr", m), {20'b0, last_wa}, 32'h022);
            chk($sformatf("st%0d_data", m), {16'b0, last_wd}, 32'h8000);
        end
        rand_mode = 1'b0;
        hold_chk  = 1'b0;

        // acc=0: BEQ 0x40 taken, BNE 0x50 not taken
        begin_prog();
        load(12'h000, 16'h1000);
        load(12'h001, 16'h9040);
        load(12'h040, 16'hA050);
        load(12'h041, 16'hF000);
        release_prog();
        run_halt(cyc);
        chk("br_reads",  rd_cnt, 32'd4);
        chk("br_fetch2", {20'b0, rd_log[2]}, 32'h040);
        chk("br_fetch3", {20'b0, rd_log[3]}, 32'h041);

        // Reset during a stalled data read
        begin_prog();
        load(12'h000, 16'h1123);
        load(12'h001, 16'h2020);
        load(12'h002, 16'hF000);
        stall = 1'b1;
        release_prog();
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (mem_req && mem_addr == 12'h020) found = 1;
        end
        chk("stall_reached", found, 32'd1);
        repeat (3) step();
        chk("stall_req_held", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        step();
        chk("midrst_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_pc",  {20'b0, dut.pc_q}, 32'h000);
        chk("midrst_acc", {16'b0, dut.acc_q}, 32'h0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        chk("restart_fetch", {11'b0, mem_req, mem_we, mem_addr}, {11'b0, 1'b1, 1'b0, 12'h000});
        run_halt(cyc);

`ifdef ACC_STACK_EN
        // LDI 9; PUSH; LDI 0; POP; OUT; HALT
        begin_prog();
        load(12'h000, 16'h1009);
        load(12'h001, 16'hE000);
        load(12'h002, 16'h1000);
        load(12'h003, 16'hE001);
        load(12'h004, 16'hD000);
        load(12'h005, 16'hF000);
        release_prog();
        run_halt(cyc);
        chk("stk_wr_cnt", wr_cnt, 32'd1);
        chk("stk_addr",   {20'b0, last_wa}, 32'hFFE);
        chk("stk_data",   {16'b0, last_wd}, 32'h9);
        chk("stk_io_out", {16'b0, io_out}, 32'h9);
        chk("stk_sp",     {20'b0, dut.sp_q}, 32'hFFF);
        chk("stk_cycles", cyc, 32'd1 + 32'd3 + 32'd4 + 32'd3 + 32'd4 + 32'd3 + 32'd2);
`else
        // Op 14 behaves as NOP: LDI 7; op14; OUT; HALT
        begin_prog();
        load(12'h000, 16'h1007);
        load(12'h001, 16'hE000);
        load(12'h002, 16'hD000);
        load(12'h003, 16'hF000);
        release_prog();
        run_halt(cyc);
        chk("op14_wr_cnt", wr_cnt, 32'd0);
        chk("op14_reads",  rd_cnt, 32'd4);
        chk("op14_io_out", {16'b0, io_out}, 32'h7);
        chk("op14_cycles", cyc, 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
